regfile_wb_arbiter: RTL

Write-port arbiter for the 32×32 MIPS register file. The register file has one write port (`write`, `reg_write`, `wdata`), and two writeback sources compete for it: the ALU result path and the load/memory return path. This block gives each source a one-entry holding register with a valid/ready handshake and picks one pending write per cycle. It preserves write order to the same register and offers a pending-write query that the hazard unit uses to stall.

---
 rtl/mips_pkg.sv | 17 +
 rtl/wb_hold_slot.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS writeback definitions: default widths, source indices and the writeback entry payload.
package mips_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  localparam int unsigned SRC_W = 1;
  localparam logic [SRC_W-1:0] SRC_ALU = 1'b0;
  localparam logic [SRC_W-1:0] SRC_MEM = 1'b1;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding register with full flag and valid/ready handshake.
module wb_hold_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready_c,
  output logic              fill_c,
  output logic              full,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_data
);

  // A slot being drained this cycle can take a new entry at the same edge.
  assign ready_c = !full || grant;
  assign fill_c  = valid && ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
    end else if (fill_c) begin
      full   <= 1'b1;
      q_addr <= addr;
      q_data <= data;
    end else if (grant) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between ALU and load writeback sources.
// Define WB_ROUND_ROBIN_EN for round-robin contention; default build gives loads fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = mips_pkg::DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit
);

  import mips_pkg::*;

  logic [1:0]        full;
  logic [1:0]        fill;
  logic [1:0]        grant;
  logic [1:0]        keep;
  logic [ADDR_W-1:0] q_addr [2];
  logic [DATA_W-1:0] q_data [2];
  logic              both_full;
  logic              pick_mem;
  logic              mem_older;
  logic              mem_older_nxt;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (alu_valid),
    .addr    (alu_addr),
    .data    (alu_data),
    .grant   (grant[SRC_ALU]),
    .ready_c (alu_ready),
    .fill_c  (fill[SRC_ALU]),
    .full    (full[SRC_ALU]),
    .q_addr  (q_addr[SRC_ALU]),
    .q_data  (q_data[SRC_ALU])
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (mem_valid),
    .addr    (mem_addr),
    .data    (mem_data),
    .grant   (grant[SRC_MEM]),
    .ready_c (mem_ready),
    .fill_c  (fill[SRC_MEM]),
    .full    (full[SRC_MEM]),
    .q_addr  (q_addr[SRC_MEM]),
    .q_data  (q_data[SRC_MEM])
  );

`ifdef WB_ROUND_ROBIN_EN
  logic rr_mem;

  // Pointer flips on every cycle where both slots compete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_mem <= 1'b1;
    end else if (both_full) begin
      rr_mem <= !rr_mem;
    end
  end
`endif

  // Same-address contention always goes to the older entry to keep write order.
  always_comb begin
    both_full = full[SRC_ALU] && full[SRC_MEM];
`ifdef WB_ROUND_ROBIN_EN
    pick_mem  = (q_addr[SRC_ALU] == q_addr[SRC_MEM]) ? mem_older : rr_mem;
`else
    pick_mem  = (q_addr[SRC_ALU] == q_addr[SRC_MEM]) ? mem_older : 1'b1;
`endif
    grant          = '0;
    grant[SRC_MEM] = full[SRC_MEM] && (!full[SRC_ALU] || pick_mem);
    grant[SRC_ALU] = full[SRC_ALU] && (!full[SRC_MEM] || !pick_mem);
    win_addr       = grant[SRC_MEM] ? q_addr[SRC_MEM] : q_addr[SRC_ALU];
    win_data       = grant[SRC_MEM] ? q_data[SRC_MEM] : q_data[SRC_ALU];
  end

  // An entry surviving the edge is older than any fill; simultaneous fills make mem older.
  always_comb begin
    keep          = full & ~grant;
    mem_older_nxt = mem_older;
    if (keep[SRC_ALU] != keep[SRC_MEM]) begin
      mem_older_nxt = keep[SRC_MEM];
    end else if (!keep[SRC_ALU]) begin
      mem_older_nxt = fill[SRC_MEM] || !fill[SRC_ALU];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_older <= 1'b1;
    end else begin
      mem_older <= mem_older_nxt;
    end
  end

  // r0 winners are drained without asserting the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (|grant) begin
      rf_write <= (win_addr != '0);
      rf_addr  <= win_addr;
      rf_wdata <= win_data;
    end else begin
      rf_write <= 1'b0;
    end
  end

  assign chk_hit = (chk_addr != '0) &&
                   ((full[SRC_ALU] && (q_addr[SRC_ALU] == chk_addr)) ||
                    (full[SRC_MEM] && (q_addr[SRC_MEM] == chk_addr)) ||
                    (rf_write && (rf_addr == chk_addr)));

endmodule
